// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Multiplexed seven-segment scan controller for N_DIGITS common-anode
//   digits. It captures a shadow copy of the display data on load_i and
//   scans one digit per SCAN_DIV clock slot. The first cycle of every slot
//   is an anode dead cycle, so the previous digit's segments cannot ghost
//   onto the next anode. It also supports per-digit blank and blink masks
//   and optional leading-zero suppression.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active-high, highest priority
//   data_i        hex nibbles, digit 0 in bits [3:0]
//   dp_i          decimal-point request per digit
//   blank_mask_i  1 = digit forced dark (live, not shadowed)
//   blink_mask_i  1 = digit blinks (live, not shadowed)
//   load_i        capture data_i/dp_i into the shadow registers
//   seg_o         {g,f,e,d,c,b,a}, active-low, registered
//   dp_o          decimal point, active-low, registered
//   an_o          anode enables, active-low
//   tick_o        one-cycle pulse in the last cycle of each digit slot

module seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 256,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_mask_i,
  input  logic [N_DIGITS-1:0]   blink_mask_i,
  input  logic                  load_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  tick_o
);

  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Per-digit lookup tables are padded to a power of two so that indexing
  // with r_idx can never fall outside the array.
  localparam int NSLOT = 1 << IW;

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_bcnt;
  logic                  r_bphase;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [N_DIGITS-1:0]   r_sdp;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_dead;
  logic                  w_last_idx;
  logic                  w_blink_wrap;
  logic [3:0]            w_nib_arr  [NSLOT];
  logic                  w_dark_arr [NSLOT];
  logic                  w_sdp_arr  [NSLOT];
  logic [N_DIGITS-1:0]   w_zero;
  logic [N_DIGITS-1:0]   w_lead;
  logic [6:0]            w_seg_next;
  logic                  w_dp_next;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick       = (r_pre == PW'(SCAN_DIV - 1));
  assign w_dead       = (r_pre == '0);
  assign w_last_idx   = (r_idx == IW'(N_DIGITS - 1));
  assign w_blink_wrap = (r_bcnt == BW'(BLINK_DIV - 1));

  // Leading-zero chain: w_lead[i] is set when every shadow nibble from the
  // top digit down to digit i is zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_lead
      assign w_zero[gi] = (r_shadow[4*gi +: 4] == 4'h0);
      if (gi == N_DIGITS - 1) begin : g_top
        assign w_lead[gi] = w_zero[gi];
      end else begin : g_rest
        assign w_lead[gi] = w_zero[gi] & w_lead[gi+1];
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < N_DIGITS) begin : g_real
        assign w_nib_arr[gi]  = r_shadow[4*gi +: 4];
        assign w_sdp_arr[gi]  = r_sdp[gi];
        // Digit 0 is never suppressed, so an all-zero value still shows "0".
        assign w_dark_arr[gi] = blank_mask_i[gi]
                              | (r_bphase & blink_mask_i[gi])
                              | ((LZ_SUPPRESS != 0) && (gi != 0) && w_lead[gi]);
      end else begin : g_pad
        assign w_nib_arr[gi]  = 4'h0;
        assign w_sdp_arr[gi]  = 1'b0;
        assign w_dark_arr[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    w_seg_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (!w_dark_arr[r_idx]) begin
      w_seg_next = f_decode(w_nib_arr[r_idx]);
      w_dp_next  = ~w_sdp_arr[r_idx];
    end
  end

  // Anodes are off in the dead cycle of each slot. After that, only the
  // anode for the current digit is driven low.
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_an
      assign an_o[gi] = ~(!w_dead && (r_idx == IW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
      r_shadow <= '0;
      r_sdp    <= '0;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
    end else begin
      if (load_i) begin
        r_shadow <= data_i;
        r_sdp    <= dp_i;
      end

      if (w_tick) begin
        r_pre <= '0;
        r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
        if (w_blink_wrap) begin
          r_bcnt   <= '0;
          r_bphase <= ~r_bphase;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end else begin
        r_pre <= r_pre + PW'(1);
      end

      // Segments are latched at the end of the dead cycle. A load coinciding
      // with the tick that opened this slot is therefore already visible.
      if (w_dead) begin
        r_seg <= w_seg_next;
        r_dp  <= w_dp_next;
      end
    end
  end

  assign seg_o  = r_seg;
  assign dp_o   = r_dp;
  assign tick_o = w_tick;

endmodule
